// File: rtl/prog_ctr_seq_if.sv
// Purpose: bundles the program-counter sequencer's launch/control inputs and
// its fetch-address/status outputs into one interface.
//   master : drives start/start_addr, stall and the decoded control bits
//            (halt, jmp_en, br_en, alu_flag, target); observes status.
//   slave  : the sequencer itself; consumes control, produces prog_ctr,
//            running, done, branch_taken and retired.
interface prog_ctr_seq_if #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
);
  logic              start;
  logic [PC_W-1:0]   start_addr;
  logic              stall;
  logic              halt;
  logic              jmp_en;
  logic              br_en;
  logic              alu_flag;
  logic [PC_W-1:0]   target;
  logic [PC_W-1:0]   prog_ctr;
  logic              running;
  logic              done;
  logic              branch_taken;
  logic [CNT_W-1:0]  retired;

  modport master (
    output start, start_addr, stall, halt, jmp_en, br_en, alu_flag, target,
    input  prog_ctr, running, done, branch_taken, retired
  );

  modport slave (
    input  start, start_addr, stall, halt, jmp_en, br_en, alu_flag, target,
    output prog_ctr, running, done, branch_taken, retired
  );
endinterface

// File: rtl/prog_ctr_seq.sv
// Purpose: program-counter sequencer downstream of the ALU. Chooses the next
// instruction-fetch address (sequential, jump, or taken branch), counts
// retired instructions and owns the IDLE/RUN/DONE start/done handshake.
// Ports:
//   clk   : system clock, rising-edge state updates
//   reset : synchronous, active-high; returns to IDLE with all outputs cleared
//   bus   : prog_ctr_seq_if slave modport (control in, PC/status out)
module prog_ctr_seq #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic          clk,
  input  logic          reset,
  prog_ctr_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic              bt_q, bt_d;

  // Retired count sticks at all-ones rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ret_q   <= '0;
      bt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ret_q   <= ret_d;
      bt_q    <= bt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ret_d   = ret_q;
    bt_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = RUN;
          pc_d    = bus.start_addr;
          ret_d   = '0;
        end
      end

      RUN: begin
        if (bus.start) begin
          pc_d  = bus.start_addr;
          ret_d = '0;
        end else if (bus.stall) begin
          // Hold everything; any control bits this cycle are discarded.
        end else if (bus.halt) begin
          // PC stays on the halt instruction, which still counts as retired.
          state_d = DONE;
          ret_d   = sat_inc(ret_q);
        end else if (bus.jmp_en || (bus.br_en && bus.alu_flag)) begin
          // Jump and taken branch share the same lookup-table target.
          pc_d  = bus.target;
          bt_d  = 1'b1;
          ret_d = sat_inc(ret_q);
        end else begin
          pc_d  = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          ret_d = sat_inc(ret_q);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic
  always_comb begin
    bus.running      = (state_q == RUN);
    bus.done         = (state_q == DONE);
    bus.prog_ctr     = pc_q;
    bus.retired      = ret_q;
    bus.branch_taken = bt_q;
  end

endmodule

// File: tb/tb_prog_ctr_seq.sv
module tb_prog_ctr_seq;

  localparam int PC_W  = 10;
  localparam int CNT_W = 16;

  logic clk;
  logic reset;
  int   n_assert;
  int   n_fail;

  prog_ctr_seq_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  prog_ctr_seq #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] pc, input logic [31:0] ret,
                           input logic run, input logic dn, input logic bt);
    check({tag, ".prog_ctr"}, 32'(bus.prog_ctr), pc);
    check({tag, ".retired"}, 32'(bus.retired), ret);
    check({tag, ".running"}, 32'(bus.running), 32'(run));
    check({tag, ".done"}, 32'(bus.done), 32'(dn));
    check({tag, ".branch_taken"}, 32'(bus.branch_taken), 32'(bt));
  endtask

  task automatic clear_ctl();
    bus.start    = 1'b0;
    bus.stall    = 1'b0;
    bus.halt     = 1'b0;
    bus.jmp_en   = 1'b0;
    bus.br_en    = 1'b0;
    bus.alu_flag = 1'b0;
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset = 1'b1;
    clear_ctl();
    bus.start_addr = '0;
    bus.target     = '0;
    step();
    step();
    check_all("reset", 32'h000, 0, 1'b0, 1'b0, 1'b0);

    // Launch at 0x010 and run sequentially
    reset = 1'b0;
    bus.start = 1'b1; bus.start_addr = 10'h010;
    step();
    check_all("launch", 32'h010, 0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    step();
    check_all("seq1", 32'h011, 1, 1'b1, 1'b0, 1'b0);
    step();
    check_all("seq2", 32'h012, 2, 1'b1, 1'b0, 1'b0);

    // Branch not taken, then taken
    bus.br_en = 1'b1; bus.alu_flag = 1'b0; bus.target = 10'h100;
    step();
    check_all("br_nt", 32'h013, 3, 1'b1, 1'b0, 1'b0);
    bus.alu_flag = 1'b1;
    step();
    check_all("br_tk", 32'h100, 4, 1'b1, 1'b0, 1'b1);

    // Stall for 3 cycles with jmp_en asserted (ignored)
    bus.br_en = 1'b0; bus.alu_flag = 1'b0;
    bus.stall = 1'b1; bus.jmp_en = 1'b1; bus.target = 10'h200;
    step();
    check_all("stall1", 32'h100, 4, 1'b1, 1'b0, 1'b0);
    step();
    check_all("stall2", 32'h100, 4, 1'b1, 1'b0, 1'b0);
    step();
    check_all("stall3", 32'h100, 4, 1'b1, 1'b0, 1'b0);
    bus.stall = 1'b0; bus.jmp_en = 1'b0;
    step();
    check_all("resume", 32'h101, 5, 1'b1, 1'b0, 1'b0);
    step(); step(); step(); step();
    check_all("at105", 32'h105, 9, 1'b1, 1'b0, 1'b0);

    // Halt wins over jump
    bus.halt = 1'b1; bus.jmp_en = 1'b1; bus.target = 10'h200;
    step();
    check_all("halt", 32'h105, 10, 1'b0, 1'b1, 1'b0);
    bus.jmp_en = 1'b0;
    step();
    check_all("done_hold", 32'h105, 10, 1'b0, 1'b1, 1'b0);
    bus.halt = 1'b0;

    // Relaunch from DONE at 0
    bus.start = 1'b1; bus.start_addr = 10'h000;
    step();
    check_all("relaunch", 32'h000, 0, 1'b1, 1'b0, 1'b0);

    // Restart from RUN at 0x3FE and wrap
    bus.start_addr = 10'h3FE;
    step();
    check_all("restart", 32'h3FE, 0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    step();
    check_all("wrap1", 32'h3FF, 1, 1'b1, 1'b0, 1'b0);
    step();
    check_all("wrap2", 32'h000, 2, 1'b1, 1'b0, 1'b0);

    // Unconditional jump, then jump together with branch
    bus.jmp_en = 1'b1; bus.target = 10'h2AA;
    step();
    check_all("jmp", 32'h2AA, 3, 1'b1, 1'b0, 1'b1);
    bus.br_en = 1'b1; bus.alu_flag = 1'b1; bus.target = 10'h155;
    step();
    check_all("jmp_br", 32'h155, 4, 1'b1, 1'b0, 1'b1);
    clear_ctl();
    step();
    check_all("bt_drop", 32'h156, 5, 1'b1, 1'b0, 1'b0);

    // Reset mid-RUN with a pending taken branch
    bus.start = 1'b1; bus.start_addr = 10'h050;
    step();
    check_all("run50", 32'h050, 0, 1'b1, 1'b0, 1'b0);
    bus.start = 1'b0;
    bus.br_en = 1'b1; bus.alu_flag = 1'b1; bus.target = 10'h100;
    reset = 1'b1;
    step();
    check_all("mid_reset", 32'h000, 0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    bus.halt = 1'b1; bus.jmp_en = 1'b1; bus.stall = 1'b1;
    step();
    check_all("idle_ignore", 32'h000, 0, 1'b0, 1'b0, 1'b0);
    clear_ctl();

    // Retired counter saturation
    bus.start = 1'b1; bus.start_addr = 10'h000;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 65535; i++) step();
    check("sat_reach", 32'(bus.retired), 32'h0000FFFF);
    step(); step();
    check("sat_hold", 32'(bus.retired), 32'h0000FFFF);
    check("sat_pc", 32'(bus.prog_ctr), 32'((65537) % 1024));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_ctr_seq.md
Name: prog_ctr_seq

Overview:
- Program-counter sequencer sitting directly downstream of the ALU.
- Consumes the ALU jump flag together with decoded control bits and a lookup-table branch target.
- Produces the instruction-fetch address for the next cycle.
- Owns the start/run/done handshake that the testbench and top level use to launch a program and detect its completion.

Parameters:
PC_W, 10, program counter / instruction address width (1024-entry instruction memory)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  launch request; sampled every cycle
start_addr  input  PC_W  first instruction address, loaded on accepted start
stall  input  1  hold PC and counter this cycle (RUN only)
halt  input  1  decoded halt/done instruction at current prog_ctr
jmp_en  input  1  decoded unconditional jump at current prog_ctr
br_en  input  1  decoded conditional branch at current prog_ctr
alu_flag  input  1  ALU jump flag for the current instruction (combinational, same cycle)
target  input  PC_W  absolute branch/jump target from lookup table
prog_ctr  output  PC_W  current instruction address (registered)
running  output  1  high while in RUN
done  output  1  high while in DONE; level, held until next accepted start
branch_taken  output  1  registered; high for one cycle after a redirect to target
retired  output  CNT_W  count of instructions retired since last start (registered)

Behaviour:
- Reset (sync, active high, overrides all inputs): state=IDLE, prog_ctr=0, running=0, done=0, branch_taken=0, retired=0.
- States: IDLE, RUN, DONE. running = (state==RUN), done = (state==DONE); both decoded from registered state.

IDLE:
- start=1 -> prog_ctr<=start_addr, retired<=0, state<=RUN.
- Otherwise hold.
- halt, jmp_en, br_en, alu_flag and stall are ignored.

RUN, priority highest first:
1. start=1 -> restart exactly as from IDLE (prog_ctr<=start_addr, retired<=0, branch_taken<=0).
2. stall=1 -> prog_ctr, retired and state hold; branch_taken<=0.
3. halt=1 -> state<=DONE, prog_ctr holds (stays on the halt instruction), retired+1.
4. jmp_en=1 -> prog_ctr<=target, branch_taken<=1, retired+1.
5. br_en=1 and alu_flag=1 -> prog_ctr<=target, branch_taken<=1, retired+1.
6. Otherwise -> prog_ctr<=prog_ctr+1 modulo 2^PC_W (all-ones wraps to 0), retired+1.

Additional RUN rules:
- branch_taken<=0 in every case except 4 and 5.
- br_en=1 with alu_flag=0 falls through to case 6 (not taken).
- halt together with jmp_en or br_en: halt wins.
- jmp_en together with br_en: jmp wins; the result is identical since the target is shared.

DONE:
- start=1 -> same launch as IDLE; done drops the next cycle.
- Otherwise hold prog_ctr, retired and done.

Counter and timing:
- retired saturates at 2^CNT_W-1; no wrap.
- Redirect latency: target appears on prog_ctr one clock after the cycle in which jmp_en, or br_en&alu_flag, is sampled. No delay slot; the sequential instruction is never presented.
- Reset mid-RUN: the next cycle is IDLE with all outputs at their reset values. Pending stall or branch conditions are discarded.

Test Plan:
- Reset, then start=1 with start_addr=0x010 for one cycle, no control bits -> running=1; prog_ctr 0x010, 0x011, 0x012 on successive clocks; retired 0, 1, 2.
- At prog_ctr=0x012 assert br_en=1, alu_flag=0, then br_en=1, alu_flag=1, target=0x100 -> first: prog_ctr=0x013, branch_taken=0; second: prog_ctr=0x100 next cycle, branch_taken=1 for exactly one cycle.
- RUN with stall=1 for 3 cycles at prog_ctr=0x100 -> prog_ctr and retired frozen for 3 cycles; jmp_en asserted during stall is ignored; advance resumes on release.
- halt=1 with jmp_en=1, target=0x200 at prog_ctr=0x105 -> done=1 and running=0 next cycle; prog_ctr stays 0x105; retired increments once, then holds; a later start with start_addr=0 returns to RUN with done=0.
- start_addr=0x3FE, run 3 cycles -> prog_ctr 0x3FE, 0x3FF, 0x000 (wrap).
- Assert reset for one cycle mid-RUN at prog_ctr=0x050 with br_en=1, alu_flag=1 -> next cycle IDLE, prog_ctr=0, retired=0, branch_taken=0, running=0, done=0.
